// File: rtl/cv32e40s_fetch_req_ctrl.sv
// rtl/cv32e40s_fetch_req_ctrl.sv - instruction fetch request generator with outstanding limit,
// address tagging FIFO and stale-response discard ahead of the alignment buffer.
module cv32e40s_fetch_req_ctrl #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        halt_i,
  input  logic        fetch_ready_i,
  output logic        trans_valid_o,
  input  logic        trans_ready_i,
  output logic [31:0] trans_addr_o,
  input  logic        resp_valid_i,
  input  logic [31:0] resp_rdata_i,
  input  logic        resp_err_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_rdata_o,
  output logic [31:0] instr_addr_o,
  output logic        instr_err_o,
  output logic [2:0]  outstanding_o,
  output logic        busy_o,
  output logic        protocol_err_o
);

  // FIFO occupancy always equals the outstanding count, so a power-of-two ring with
  // free-running pointers never overflows and needs no separate full/empty tracking.
  localparam int              AW      = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int              DEPTH   = 1 << AW;
  localparam logic [AW-1:0]   PTR_ONE = 1;
  localparam logic [2:0]      MAX_CNT = 3'(MAX_OUTSTANDING);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e        r_state;
  state_e        w_state_nxt;
  logic [31:0]   r_next_addr;
  logic [2:0]    r_outstanding;
  logic [2:0]    r_discard_cnt;
  logic [31:0]   r_fifo [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;

  logic [31:0]   w_branch_addr;
  logic [31:0]   w_trans_addr;
  logic          w_trans_valid;
  logic          w_accept;
  logic          w_resp_legal;
  logic          w_resp_illegal;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (branch_i) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (halt_i && !branch_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A branch issues its target in the same cycle, even from IDLE.
  assign w_branch_addr  = {branch_addr_i[31:2], 2'b00};
  assign w_trans_addr   = branch_i ? w_branch_addr : r_next_addr;
  assign w_trans_valid  = ((r_state == S_RUN) || branch_i) && fetch_ready_i &&
                          (r_outstanding < MAX_CNT);
  assign w_accept       = w_trans_valid && trans_ready_i;
  assign w_resp_legal   = resp_valid_i && (r_outstanding != 3'd0);
  assign w_resp_illegal = resp_valid_i && (r_outstanding == 3'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_next_addr <= 32'd0;
    end else if (w_accept) begin
      r_next_addr <= w_trans_addr + 32'd4;
    end else if (branch_i) begin
      r_next_addr <= w_branch_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= 3'd0;
    end else if (w_accept && !w_resp_legal) begin
      r_outstanding <= r_outstanding + 3'd1;
    end else if (!w_accept && w_resp_legal) begin
      r_outstanding <= r_outstanding - 3'd1;
    end
  end

  // A branch marks every response still owed for older requests as stale; the
  // request accepted alongside the branch belongs to the new stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_discard_cnt <= 3'd0;
    end else if (branch_i) begin
      r_discard_cnt <= r_outstanding - (w_resp_legal ? 3'd1 : 3'd0);
    end else if (w_resp_legal && (r_discard_cnt != 3'd0)) begin
      r_discard_cnt <= r_discard_cnt - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo[i] <= 32'd0;
      end
    end else begin
      if (w_accept) begin
        r_fifo[r_wptr] <= w_trans_addr;
        r_wptr         <= r_wptr + PTR_ONE;
      end
      if (w_resp_legal) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
    end
  end

  assign trans_valid_o  = w_trans_valid;
  assign trans_addr_o   = w_trans_addr;
  assign instr_valid_o  = w_resp_legal && (r_discard_cnt == 3'd0) && !branch_i;
  assign instr_rdata_o  = resp_rdata_i;
  assign instr_err_o    = resp_err_i;
  assign instr_addr_o   = r_fifo[r_rptr];
  assign outstanding_o  = r_outstanding;
  assign busy_o         = (r_outstanding != 3'd0);
  assign protocol_err_o = w_resp_illegal;

endmodule

// File: tb/tb_cv32e40s_fetch_req_ctrl.sv
// tb/tb_cv32e40s_fetch_req_ctrl.sv - directed vector bench for cv32e40s_fetch_req_ctrl.
module tb_cv32e40s_fetch_req_ctrl;

  logic        clk;
  logic        rst_n;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        halt_i;
  logic        fetch_ready_i;
  logic        trans_valid_o;
  logic        trans_ready_i;
  logic [31:0] trans_addr_o;
  logic        resp_valid_i;
  logic [31:0] resp_rdata_i;
  logic        resp_err_i;
  logic        instr_valid_o;
  logic [31:0] instr_rdata_o;
  logic [31:0] instr_addr_o;
  logic        instr_err_o;
  logic [2:0]  outstanding_o;
  logic        busy_o;
  logic        protocol_err_o;

  cv32e40s_fetch_req_ctrl #(.MAX_OUTSTANDING(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .branch_i       (branch_i),
    .branch_addr_i  (branch_addr_i),
    .halt_i         (halt_i),
    .fetch_ready_i  (fetch_ready_i),
    .trans_valid_o  (trans_valid_o),
    .trans_ready_i  (trans_ready_i),
    .trans_addr_o   (trans_addr_o),
    .resp_valid_i   (resp_valid_i),
    .resp_rdata_i   (resp_rdata_i),
    .resp_err_i     (resp_err_i),
    .instr_valid_o  (instr_valid_o),
    .instr_rdata_o  (instr_rdata_o),
    .instr_addr_o   (instr_addr_o),
    .instr_err_o    (instr_err_o),
    .outstanding_o  (outstanding_o),
    .busy_o         (busy_o),
    .protocol_err_o (protocol_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        br;
    logic [31:0] ba;
    logic        halt;
    logic        fr;
    logic        tr;
    logic        rv;
    logic [31:0] rd;
    logic        re;
    logic        tv;
    logic [31:0] ta;
    logic        iv;
    logic [31:0] ia;
    logic [2:0]  outs;
    logic        perr;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic add(input logic br, input logic [31:0] ba, input logic halt, input logic fr,
                     input logic tr, input logic rv, input logic [31:0] rd, input logic re,
                     input logic tv, input logic [31:0] ta, input logic iv, input logic [31:0] ia,
                     input logic [2:0] outs, input logic perr);
    vec_t v;
    v.br = br; v.ba = ba; v.halt = halt; v.fr = fr; v.tr = tr; v.rv = rv; v.rd = rd; v.re = re;
    v.tv = tv; v.ta = ta; v.iv = iv; v.ia = ia; v.outs = outs; v.perr = perr;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic br, input logic [31:0] ba, input logic halt, input logic fr,
                       input logic tr, input logic rv, input logic [31:0] rd, input logic re);
    @(negedge clk);
    branch_i = br; branch_addr_i = ba; halt_i = halt; fetch_ready_i = fr;
    trans_ready_i = tr; resp_valid_i = rv; resp_rdata_i = rd; resp_err_i = re;
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  initial begin
    logic [104:0] got;
    logic [104:0] want;
    rst_n = 1'b0;
    branch_i = 0; branch_addr_i = 0; halt_i = 0; fetch_ready_i = 0;
    trans_ready_i = 0; resp_valid_i = 0; resp_rdata_i = 0; resp_err_i = 0;

    //   br ba            hlt fr tr rv rd            re   tv ta            iv ia            out perr
    add(0, 32'h0,         0, 0, 0, 0, 32'h0,        0,   0, 32'h0,         0, 32'h0,        0, 0);
    add(1, 32'h80000003,  0, 1, 1, 0, 32'h0,        0,   1, 32'h80000000,  0, 32'h0,        0, 0);
    add(0, 32'h0,         0, 1, 1, 0, 32'h0,        0,   1, 32'h80000004,  0, 32'h80000000, 1, 0);
    add(0, 32'h0,         0, 1, 1, 0, 32'h0,        0,   0, 32'h80000008,  0, 32'h80000000, 2, 0);
    add(0, 32'h0,         0, 1, 1, 1, 32'hAAAA0001, 0,   0, 32'h80000008,  1, 32'h80000000, 2, 0);
    add(0, 32'h0,         0, 1, 1, 1, 32'hBBBB0002, 1,   1, 32'h80000008,  1, 32'h80000004, 1, 0);
    add(0, 32'h0,         1, 1, 1, 0, 32'h0,        0,   1, 32'h8000000C,  0, 32'h80000008, 1, 0);
    add(0, 32'h0,         0, 1, 1, 1, 32'h00000011, 0,   0, 32'h80000010,  1, 32'h80000008, 2, 0);
    add(0, 32'h0,         0, 1, 1, 1, 32'h00000022, 0,   0, 32'h80000010,  1, 32'h8000000C, 1, 0);
    add(0, 32'h0,         0, 1, 1, 0, 32'h0,        0,   0, 32'h80000010,  0, 32'h80000008, 0, 0);
    add(0, 32'h0,         0, 1, 1, 1, 32'h00000033, 0,   0, 32'h80000010,  0, 32'h80000008, 0, 1);
    add(0, 32'h0,         0, 0, 0, 0, 32'h0,        0,   0, 32'h80000010,  0, 32'h80000008, 0, 0);
    add(1, 32'h00000100,  0, 1, 1, 0, 32'h0,        0,   1, 32'h00000100,  0, 32'h80000008, 0, 0);
    add(0, 32'h0,         0, 1, 1, 0, 32'h0,        0,   1, 32'h00000104,  0, 32'h00000100, 1, 0);
    add(1, 32'h00000200,  0, 1, 1, 1, 32'hD0000100, 0,   0, 32'h00000200,  0, 32'h00000100, 2, 0);
    add(0, 32'h0,         0, 1, 1, 1, 32'hD0000104, 0,   1, 32'h00000200,  0, 32'h00000104, 1, 0);
    add(0, 32'h0,         0, 0, 1, 1, 32'hD0000200, 0,   0, 32'h00000204,  1, 32'h00000200, 1, 0);
    add(0, 32'h0,         0, 0, 1, 0, 32'h0,        0,   0, 32'h00000204,  0, 32'h00000104, 0, 0);
    add(0, 32'h0,         0, 1, 0, 0, 32'h0,        0,   1, 32'h00000204,  0, 32'h00000104, 0, 0);
    add(1, 32'h00000302,  0, 1, 0, 0, 32'h0,        0,   1, 32'h00000300,  0, 32'h00000104, 0, 0);
    add(0, 32'h0,         0, 1, 0, 0, 32'h0,        0,   1, 32'h00000300,  0, 32'h00000104, 0, 0);
    add(0, 32'h0,         0, 1, 1, 0, 32'h0,        0,   1, 32'h00000300,  0, 32'h00000104, 0, 0);
    add(0, 32'h0,         0, 0, 1, 1, 32'hD0000300, 0,   0, 32'h00000304,  1, 32'h00000300, 1, 0);
    add(1, 32'hFFFFFFFF,  0, 1, 1, 0, 32'h0,        0,   1, 32'hFFFFFFFC,  0, 32'h00000200, 0, 0);
    add(0, 32'h0,         0, 1, 1, 0, 32'h0,        0,   1, 32'h00000000,  0, 32'hFFFFFFFC, 1, 0);
    add(0, 32'h0,         1, 1, 1, 0, 32'h0,        0,   0, 32'h00000004,  0, 32'hFFFFFFFC, 2, 0);
    add(0, 32'h0,         0, 1, 1, 1, 32'hD000FFFC, 0,   0, 32'h00000004,  1, 32'hFFFFFFFC, 2, 0);
    add(0, 32'h0,         0, 1, 1, 1, 32'hD0000000, 1,   0, 32'h00000004,  1, 32'h00000000, 1, 0);
    add(0, 32'h0,         0, 1, 1, 0, 32'h0,        0,   0, 32'h00000004,  0, 32'hFFFFFFFC, 0, 0);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].br, vecs[i].ba, vecs[i].halt, vecs[i].fr, vecs[i].tr,
            vecs[i].rv, vecs[i].rd, vecs[i].re);
      got  = {trans_valid_o, trans_addr_o, instr_valid_o, instr_addr_o, instr_rdata_o,
              instr_err_o, outstanding_o, busy_o, protocol_err_o};
      want = {vecs[i].tv, vecs[i].ta, vecs[i].iv, vecs[i].ia, vecs[i].rd, vecs[i].re,
              vecs[i].outs, (vecs[i].outs != 3'd0), vecs[i].perr};
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL vec%0d: got tv=%b ta=%h iv=%b ia=%h rd=%h er=%b out=%0d busy=%b perr=%b, expected tv=%b ta=%h iv=%b ia=%h rd=%h er=%b out=%0d busy=%b perr=%b",
                    i, trans_valid_o, trans_addr_o, instr_valid_o, instr_addr_o, instr_rdata_o,
                    instr_err_o, outstanding_o, busy_o, protocol_err_o,
                    want[104], want[103:72], want[71], want[70:39], want[38:7], want[6],
                    want[5:3], want[2], want[0]);
    end

    // Back-to-back branches reload the discard count; branch overrides halt.
    drive(1, 32'h400, 1, 1, 1, 0, 32'h0, 0);
    check("br_halt_tv", {31'd0, trans_valid_o}, 32'd1);
    drive(0, 32'h0, 0, 1, 1, 0, 32'h0, 0);
    check("run_after_br_halt_ta", trans_addr_o, 32'h404);
    check("run_after_br_halt_tv", {31'd0, trans_valid_o}, 32'd1);
    drive(1, 32'h500, 0, 1, 0, 0, 32'h0, 0);
    check("br1_out", {29'd0, outstanding_o}, 32'd2);
    drive(1, 32'h600, 0, 1, 0, 1, 32'hE0000400, 0);
    check("br2_drop_iv", {31'd0, instr_valid_o}, 32'd0);
    drive(0, 32'h0, 0, 0, 0, 1, 32'hE0000404, 0);
    check("stale_drop_iv", {31'd0, instr_valid_o}, 32'd0);
    drive(0, 32'h0, 0, 1, 1, 0, 32'h0, 0);
    check("reload_ta", trans_addr_o, 32'h600);
    drive(0, 32'h0, 0, 0, 0, 1, 32'hE0000600, 0);
    check("reload_fwd_iv", {31'd0, instr_valid_o}, 32'd1);
    check("reload_fwd_ia", instr_addr_o, 32'h600);
    drive(0, 32'h0, 0, 1, 1, 0, 32'h0, 0);
    check("pre_reset_tv", {31'd0, trans_valid_o}, 32'd1);

    // Asynchronous reset clears state without waiting for a clock edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out", {29'd0, outstanding_o}, 32'd0);
    check("async_rst_tv", {31'd0, trans_valid_o}, 32'd0);
    check("async_rst_ta", trans_addr_o, 32'd0);
    branch_i = 0; fetch_ready_i = 0; trans_ready_i = 0; resp_valid_i = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
